// File: rtl/adder_share_pkg.sv
// Shared constants and state encoding for the shared-adder sequencer.
// Operand width is split into a 5-bit exponent and an 11-bit mantissa field.
package adder_share_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 11;
  localparam int W       = EXP_W + MAN_W;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_share_ctrl_rr_picker.sv
// Combinational round-robin picker: one-hot grant searched from pointer+1
// modulo NREQ, plus the binary index of the winner.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // k runs 1..NREQ so the current pointer holder is checked last
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one combinational adder among NREQ requesters.
// Optional ADDER_SHARE_STATS_EN adds stat_ops, a saturating count of responses.
//
//   state | meaning
//   IDLE  | grant a valid requester, load operands into add_a/add_b
//   WAIT  | let the shared adder settle for LAT cycles, then capture add_sum
//   RESP  | present rsp_sum to the granted requester until rsp_ready
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    rsp_sum,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  input  logic [W-1:0]    add_sum,
  output logic            busy
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [15:0]     stat_ops
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gid;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_add_a;
  logic [W-1:0]     r_add_b;
  logic [W-1:0]     r_rsp_sum;

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_gidx;
  logic             w_any;
  logic             w_rsp_hs;
  logic [W-1:0]     w_a_arr [NREQ];
  logic [W-1:0]     w_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*W +: W];
    assign w_b_arr[g] = req_b[g*W +: W];
  end

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_gid];

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[r_gid] = 1'b1;
        if (rsp_ready[r_gid]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= IDX_W'(NREQ - 1);
      r_gid     <= '0;
      r_cnt     <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_rsp_sum <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_add_a <= w_a_arr[w_gidx];
            r_add_b <= w_b_arr[w_gidx];
            r_gid   <= w_gidx;
            r_cnt   <= CNT_W'(LAT - 1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_rsp_sum <= add_sum;
          else             r_cnt     <= r_cnt - CNT_W'(1);
        end
        RESP: begin
          // pointer only advances once the response is actually taken
          if (w_rsp_hs) r_ptr <= r_gid;
        end
        default: ;
      endcase
    end
  end

  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign rsp_sum = r_rsp_sum;
  assign busy    = (r_state != IDLE);

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] r_stat_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stat_ops <= '0;
    else if (w_rsp_hs && (r_stat_ops != 16'hFFFF))
      r_stat_ops <= r_stat_ops + 16'd1;
  end

  assign stat_ops = r_stat_ops;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: instance A (NREQ=2, LAT=1) and
// instance B (NREQ=4, LAT=3), each with a stub adder returning a+b.
module tb_adder_share_ctrl;
  import adder_share_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]     req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  logic [2*W-1:0] req_a_a, req_b_a;
  logic [W-1:0]   rsp_sum_a, add_a_a, add_b_a, add_sum_a;
  logic           busy_a;

  logic [3:0]     req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [4*W-1:0] req_a_b, req_b_b;
  logic [W-1:0]   rsp_sum_b, add_a_b, add_b_b, add_sum_b;
  logic           busy_b;

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] stat_ops_a, stat_ops_b;
`endif

  assign add_sum_a = add_a_a + add_b_a;
  assign add_sum_b = add_a_b + add_b_b;

  adder_share_ctrl #(.NREQ(2), .LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_a(req_a_a), .req_b(req_b_a),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_sum(rsp_sum_a), .add_a(add_a_a), .add_b(add_b_a),
    .add_sum(add_sum_a), .busy(busy_a)
`ifdef ADDER_SHARE_STATS_EN
    , .stat_ops(stat_ops_a)
`endif
  );

  adder_share_ctrl #(.NREQ(4), .LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_a(req_a_b), .req_b(req_b_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_sum(rsp_sum_b), .add_a(add_a_b), .add_b(add_b_b),
    .add_sum(add_sum_b), .busy(busy_b)
`ifdef ADDER_SHARE_STATS_EN
    , .stat_ops(stat_ops_b)
`endif
  );

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int ops_a = 0;
  int ops_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  // single-requester operation on instance A, LAT=1
  task automatic op_a(input int idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    logic [1:0] oh;
    int n;
    oh = 2'b01 << idx;
    drv_edge();
    req_a_a[idx*W +: W] = a;
    req_b_a[idx*W +: W] = b;
    req_valid_a = oh;
    rsp_ready_a = 2'b00;
    @(negedge clk);
    chk("a_grant", req_ready_a, oh);
    drv_edge();
    req_valid_a = 2'b00;
    @(negedge clk);
    chk("a_add_a", add_a_a, a);
    chk("a_add_b", add_b_a, b);
    chk("a_busy", busy_a, 1'b1);
    n = 1;
    while (rsp_valid_a == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_latency", n, 2);
    chk("a_rsp_valid", rsp_valid_a, oh);
    chk("a_rsp_sum", rsp_sum_a, exp);
    drv_edge();
    rsp_ready_a = oh;
    drv_edge();
    rsp_ready_a = 2'b00;
    ops_a++;
    @(negedge clk);
    chk("a_idle_busy", busy_a, 1'b0);
    chk("a_idle_rsp", rsp_valid_a, 2'b00);
  endtask

  // waits for any rsp_valid on B; returns cycles counted
  task automatic wait_rsp_b(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid_b != 4'b0000) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv [6];
    int   n;
    logic any_rsp;
    logic [15:0] exp_rot [2];

    tv[0] = '{0, 16'h2D55, 16'h5201, 16'h7F56};
    tv[1] = '{1, 16'hC8FF, 16'h4920, 16'h121F};
    tv[2] = '{0, 16'hFFFF, 16'h0001, 16'h0000};
    tv[3] = '{1, 16'h3C00, 16'h3C00, 16'h7800};
    tv[4] = '{0, 16'h1234, 16'h4321, 16'h5555};
    tv[5] = '{1, 16'h7C00, 16'h03FF, 16'h7FFF};
    exp_rot[0] = 16'h3333;
    exp_rot[1] = 16'h121F;

    rst_n = 1'b1;
    req_valid_a = '0; req_a_a = '0; req_b_a = '0; rsp_ready_a = '0;
    req_valid_b = '0; req_a_b = '0; req_b_b = '0; rsp_ready_b = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_rsp_a", rsp_valid_a, 2'b00);
    chk("rst_add_a", add_a_a, 16'h0000);
    chk("rst_sum_a", rsp_sum_a, 16'h0000);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_ready_b", req_ready_b, 4'b0000);
    drv_edge();
    rst_n = 1'b1;

    // table-driven single operations on A
    for (int i = 0; i < 6; i++) begin
      op_a(tv[i].idx, tv[i].a, tv[i].b, tv[i].sum);
`ifdef ADDER_SHARE_STATS_EN
      if (i == 4) chk("a_stat_ops5", stat_ops_a, ops_a);
`endif
    end

    // both requesters held valid, responses accepted in advance
    drv_edge();
    req_a_a = {16'hC8FF, 16'h1111};
    req_b_a = {16'h4920, 16'h2222};
    req_valid_a = 2'b11;
    rsp_ready_a = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready_a == 2'b00 && n < 20);
      chk("rot_grant", req_ready_a, 2'b01 << (k % 2));
      n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid_a == 2'b00 && n < 20);
      chk("rot_rsp", rsp_valid_a, 2'b01 << (k % 2));
      chk("rot_sum", rsp_sum_a, exp_rot[k % 2]);
      ops_a++;
    end
    drv_edge();
    req_valid_a = 2'b00;
    rsp_ready_a = 2'b00;
`ifdef ADDER_SHARE_STATS_EN
    @(negedge clk);
    chk("a_stat_ops", stat_ops_a, ops_a);
`endif

    // B: LAT=3, response stalled while requester 1 waits
    drv_edge();
    req_a_b[0*W +: W] = 16'h0100; req_b_b[0*W +: W] = 16'h0200;
    req_a_b[1*W +: W] = 16'h0005; req_b_b[1*W +: W] = 16'h0007;
    req_valid_b = 4'b0011;
    rsp_ready_b = 4'b0000;
    @(negedge clk);
    chk("b_grant0", req_ready_b, 4'b0001);
    drv_edge();
    req_valid_b = 4'b0010;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid_b != 4'b0000) break;
      chk("b_wait_ready", req_ready_b, 4'b0000);
      chk("b_wait_busy", busy_b, 1'b1);
    end
    chk("b_latency", n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("b_stall_valid", rsp_valid_b, 4'b0001);
      chk("b_stall_sum", rsp_sum_b, 16'h0300);
      chk("b_stall_ready", req_ready_b, 4'b0000);
      chk("b_stall_busy", busy_b, 1'b1);
    end
    drv_edge();
    rsp_ready_b = 4'b0001;
    drv_edge();
    rsp_ready_b = 4'b0000;
    ops_b++;
    @(negedge clk);
    chk("b_grant1", req_ready_b, 4'b0010);
    drv_edge();
    req_valid_b = 4'b0000;
    rsp_ready_b = 4'b1111;
    wait_rsp_b(n);
    chk("b_rsp1", rsp_valid_b, 4'b0010);
    chk("b_sum1", rsp_sum_b, 16'h000C);
    ops_b++;

    // pointer now 1: requesters 1 and 3 valid -> 3 first, then 1
    drv_edge();
    req_a_b[1*W +: W] = 16'h0001; req_b_b[1*W +: W] = 16'h0001;
    req_a_b[3*W +: W] = 16'h0F00; req_b_b[3*W +: W] = 16'h00F0;
    req_valid_b = 4'b1010;
    @(negedge clk);
    chk("b_grant3", req_ready_b, 4'b1000);
    drv_edge();
    req_valid_b = 4'b0010;
    wait_rsp_b(n);
    chk("b_rsp3", rsp_valid_b, 4'b1000);
    chk("b_sum3", rsp_sum_b, 16'h0FF0);
    ops_b++;
    @(negedge clk);
    chk("b_grant1b", req_ready_b, 4'b0010);
    drv_edge();
    req_valid_b = 4'b0000;
    wait_rsp_b(n);
    chk("b_rsp1b", rsp_valid_b, 4'b0010);
    chk("b_sum1b", rsp_sum_b, 16'h0002);
    ops_b++;
    drv_edge();
    rsp_ready_b = 4'b0000;
`ifdef ADDER_SHARE_STATS_EN
    @(negedge clk);
    chk("b_stat_ops", stat_ops_b, ops_b);
`endif

    // reset asserted while B is in WAIT
    drv_edge();
    req_a_b[2*W +: W] = 16'hAAAA; req_b_b[2*W +: W] = 16'h1111;
    req_valid_b = 4'b0100;
    @(negedge clk);
    chk("r_grant2", req_ready_b, 4'b0100);
    drv_edge();
    req_valid_b = 4'b0000;
    @(negedge clk);
    chk("r_add_a_pre", add_a_b, 16'hAAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("r_add_a", add_a_b, 16'h0000);
    chk("r_add_b", add_b_b, 16'h0000);
    chk("r_sum", rsp_sum_b, 16'h0000);
    chk("r_busy", busy_b, 1'b0);
    chk("r_add_a_inst_a", add_a_a, 16'h0000);
    drv_edge();
    rst_n = 1'b1;
    ops_a = 0;
    ops_b = 0;
    rsp_ready_b = 4'b1111;
    any_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_rsp = any_rsp | (|rsp_valid_b);
    end
    chk("r_no_rsp", any_rsp, 1'b0);
`ifdef ADDER_SHARE_STATS_EN
    chk("r_stat_a", stat_ops_a, ops_a);
    chk("r_stat_b", stat_ops_b, ops_b);
`endif
    drv_edge();
    req_a_b[0*W +: W] = 16'h0040; req_b_b[0*W +: W] = 16'h0004;
    req_valid_b = 4'b0101;
    @(negedge clk);
    chk("r_first_grant", req_ready_b, 4'b0001);
    drv_edge();
    req_valid_b = 4'b0000;
    wait_rsp_b(n);
    chk("r_rsp0", rsp_valid_b, 4'b0001);
    chk("r_sum0", rsp_sum_b, 16'h0044);
    ops_b++;
    drv_edge();
    rsp_ready_b = 4'b0000;
`ifdef ADDER_SHARE_STATS_EN
    @(negedge clk);
    chk("r_stat_b1", stat_ops_b, ops_b);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
